band_mixer: RTL and testbench
=============================

// Module: band_mixer
// PURPOSE
//  Synthesis end of the 5-band filterbank. Recombines the five 18-bit bandpass outputs into one 8-bit sample.
//  Applies a per-band gain to each band, sums the bands, then shifts and saturates the sum.
//  Takes the same per-sample `ready` strobe as the bandpass filters and waits for their results to settle.
//  Drives the 8-bit audio output path.
// PARAMETERS
//  WAIT_CYCLES  63  clocks from sampled ready to band snapshot (must exceed filter MAC latency of 62)
//  OUT_SHIFT    10  arithmetic right shift applied to accumulator before saturation
// PORTS
//  clock       in   1    system clock; all logic on posedge
//  reset       in   1    synchronous, active-low reset
//  ready       in   1    one-cycle new-sample strobe (same pulse fed to filters)
//  band0..4    in   18   signed filter outputs y of bands 0..4
//  gain0..4    in   4    unsigned per-band gain, 0..15 (0 = band muted)
//  y           out  8    signed mixed output sample
//  y_valid     out  1    one-cycle pulse: y updated this cycle
//  busy        out  1    high whenever state != IDLE
//  clip_count  out  16   saturating count of clipped outputs (only with BAND_MIXER_CLIPCNT_EN)
// BEHAVIOUR
//  Reset (reset==0 at an edge): state=IDLE; y=0; y_valid=0; busy=0; acc=0; clip_count=0. Reset beats ready.
//  FSM IDLE->WAIT->ACCUM->DONE->IDLE; edge E0 = edge sampling ready=1.
//  IDLE: on ready go to WAIT, cnt=WAIT_CYCLES-1.
//  WAIT: decrement cnt each edge; at edge E0+WAIT_CYCLES snapshot band0..4 and gain0..4; acc=0; idx=0; go to ACCUM.
//  ACCUM: 5 edges; acc += band_snap[idx]*gain_snap[idx]; idx++; after idx==4 go to DONE.
//  DONE: one edge; y<=sat8(acc>>>OUT_SHIFT); y_valid<=1; go to IDLE. y_valid is low on every other edge.
//  Latency: y_valid high for the cycle after edge E0+WAIT_CYCLES+6 (E0+69 at default).
//  Arithmetic: product 22b signed (gain zero-extended), acc 25b signed, so no overflow is possible.
//    Shift is arithmetic (floor, no rounding). sat8 clamps to [-128,127].
//  ready while busy (WAIT/ACCUM/DONE): abort, re-enter WAIT with cnt=WAIT_CYCLES-1.
//    The in-flight result is discarded, no y_valid for it, and y holds its previous value.
//  Input changes after the snapshot do not affect the in-flight result.
//  y holds its last value between updates.
// CONFIGURATION
//  BAND_MIXER_CLIPCNT_EN defined: clip_count port exists.
//    Increments on each DONE edge where sat8 clamped; sticks at 16'hFFFF; reset clears it.
//  Not defined: no clip_count port and no counter logic; all other behaviour identical.
// STRUCTURE
//  Shared package filterbank_pkg:
//    NUM_BANDS=5, SAMPLE_W=8, BAND_W=18, GAIN_W=4, ACC_W=25;
//    FSM state encoding (IDLE, WAIT, ACCUM, DONE).
//  Sub-module band_mixer_sat: combinational shift-by-OUT_SHIFT plus clamp; outputs y8 and a clipped flag.
//  Snapshot registers and product mux are indexed by idx (3b).
// TESTING
//  1. reset low 3 cycles while ready pulses -> y=0, y_valid=0, busy=0 throughout; no later y_valid.
//  2. bands all 1024, gains all 1, ready at E0 -> y=5 (5120>>>10), y_valid only after edge E0+69; busy high E0..E0+69.
//  3. band0=131071, gain0=15, others gain 0 -> y=127.
//     band0=-131072, gain0=15 -> y=-128; clip_count=2 with macro.
//  4. band0=-1, gain0=1, rest gain 0 -> y=-1 (floor shift).
//     band2=2047, gain2=1 -> y=1; clip_count unchanged.
//  5. ready at E0 and again at E0+30 -> exactly one y_valid, after edge E0+99; result uses inputs present at E0+93.
//  6. bands change every cycle during ACCUM -> y matches the values present at snapshot edge E0+63.
//     reset low at E0+66 -> no y_valid, y=0.

Source files
------------

// File: rtl/filterbank_pkg.sv
`default_nettype none
// ============================================================================
// Module   : filterbank_pkg
// Purpose  : Shared widths and mixer FSM encoding for the 5-band filterbank.
// Revision : 1.0 - initial release
// ============================================================================
package filterbank_pkg;

  localparam int NUM_BANDS = 5;
  localparam int SAMPLE_W  = 8;
  localparam int BAND_W    = 18;
  localparam int GAIN_W    = 4;
  localparam int ACC_W     = 25;
  localparam int PROD_W    = BAND_W + GAIN_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_ACCUM = 2'd2,
    S_DONE  = 2'd3
  } mix_state_t;

endpackage
`default_nettype wire

// File: rtl/band_mixer_sat.sv
`default_nettype none
// ============================================================================
// Module   : band_mixer_sat
// Purpose  : Arithmetic (floor) right shift of the accumulator, clamp to 8 bits.
// Revision : 1.0 - initial release
// ============================================================================
module band_mixer_sat
  import filterbank_pkg::*;
#(
  parameter int OUT_SHIFT = 10
) (
  input  logic [ACC_W-1:0]    acc,
  output logic [SAMPLE_W-1:0] y8,
  output logic                clipped
);

  localparam logic signed [ACC_W-1:0] c_sat_max = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] c_sat_min = ACC_W'(-128);

  logic signed [ACC_W-1:0] w_shifted;

  assign w_shifted = $signed(acc) >>> OUT_SHIFT;

  always_comb begin
    y8      = w_shifted[SAMPLE_W-1:0];
    clipped = 1'b0;
    if (w_shifted > c_sat_max) begin
      y8      = 8'h7F;
      clipped = 1'b1;
    end else if (w_shifted < c_sat_min) begin
      y8      = 8'h80;
      clipped = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/band_mixer.sv
`default_nettype none
// ============================================================================
// Module   : band_mixer
// Purpose  : Waits for the bandpass results to settle after ready, then mixes
//            the five gained bands into one saturated 8-bit sample.
//            Optional clip counter enabled by BAND_MIXER_CLIPCNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module band_mixer
  import filterbank_pkg::*;
#(
  parameter int WAIT_CYCLES = 63,
  parameter int OUT_SHIFT   = 10
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ready,
  input  logic [BAND_W-1:0]   band0,
  input  logic [BAND_W-1:0]   band1,
  input  logic [BAND_W-1:0]   band2,
  input  logic [BAND_W-1:0]   band3,
  input  logic [BAND_W-1:0]   band4,
  input  logic [GAIN_W-1:0]   gain0,
  input  logic [GAIN_W-1:0]   gain1,
  input  logic [GAIN_W-1:0]   gain2,
  input  logic [GAIN_W-1:0]   gain3,
  input  logic [GAIN_W-1:0]   gain4,
  output logic [SAMPLE_W-1:0] y,
  output logic                y_valid,
  output logic                busy
`ifdef BAND_MIXER_CLIPCNT_EN
  ,
  output logic [15:0]         clip_count
`endif
);

  localparam int              CNT_W      = $clog2(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(WAIT_CYCLES - 1);

  mix_state_t r_state, w_state_nxt;

  logic [CNT_W-1:0]    r_cnt;
  logic [2:0]          r_idx;
  logic [ACC_W-1:0]    r_acc;
  logic [BAND_W-1:0]   r_band_snap [NUM_BANDS];
  logic [GAIN_W-1:0]   r_gain_snap [NUM_BANDS];
  logic [BAND_W-1:0]   w_band_in   [NUM_BANDS];
  logic [GAIN_W-1:0]   w_gain_in   [NUM_BANDS];
  logic [BAND_W-1:0]   w_band_sel;
  logic [GAIN_W-1:0]   w_gain_sel;
  logic signed [PROD_W-1:0] w_prod;
  logic                w_load, w_dec, w_snap, w_acc_en, w_done;
  logic [SAMPLE_W-1:0] w_y8;
  logic                w_clipped;

  assign w_band_in[0] = band0;
  assign w_band_in[1] = band1;
  assign w_band_in[2] = band2;
  assign w_band_in[3] = band3;
  assign w_band_in[4] = band4;
  assign w_gain_in[0] = gain0;
  assign w_gain_in[1] = gain1;
  assign w_gain_in[2] = gain2;
  assign w_gain_in[3] = gain3;
  assign w_gain_in[4] = gain4;

  assign busy = (r_state != S_IDLE);

  always_ff @(posedge clock) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // A new ready always restarts the wait, discarding any in-flight mix.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_dec       = 1'b0;
    w_snap      = 1'b0;
    w_acc_en    = 1'b0;
    w_done      = 1'b0;
    if (ready) begin
      w_state_nxt = S_WAIT;
      w_load      = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: w_state_nxt = S_IDLE;
        S_WAIT: begin
          if (r_cnt == '0) begin
            w_snap      = 1'b1;
            w_state_nxt = S_ACCUM;
          end else begin
            w_dec = 1'b1;
          end
        end
        S_ACCUM: begin
          w_acc_en = 1'b1;
          if (r_idx == 3'd4) w_state_nxt = S_DONE;
        end
        S_DONE: begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_band_sel = '0;
    w_gain_sel = '0;
    for (int i = 0; i < NUM_BANDS; i++) begin
      if (r_idx == 3'(i)) begin
        w_band_sel = r_band_snap[i];
        w_gain_sel = r_gain_snap[i];
      end
    end
  end

  // Gain is zero-extended so the product stays signed without a sign flip.
  assign w_prod = $signed({{(PROD_W-BAND_W){w_band_sel[BAND_W-1]}}, w_band_sel})
                * $signed({{(PROD_W-GAIN_W){1'b0}}, w_gain_sel});

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_acc   <= '0;
      y       <= '0;
      y_valid <= 1'b0;
      for (int i = 0; i < NUM_BANDS; i++) begin
        r_band_snap[i] <= '0;
        r_gain_snap[i] <= '0;
      end
    end else begin
      y_valid <= w_done;
      if (w_load)     r_cnt <= c_cnt_load;
      else if (w_dec) r_cnt <= r_cnt - 1'b1;
      if (w_snap) begin
        for (int i = 0; i < NUM_BANDS; i++) begin
          r_band_snap[i] <= w_band_in[i];
          r_gain_snap[i] <= w_gain_in[i];
        end
        r_acc <= '0;
        r_idx <= '0;
      end else if (w_acc_en) begin
        r_acc <= r_acc + {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
        r_idx <= r_idx + 3'd1;
      end
      if (w_done) y <= w_y8;
    end
  end

  band_mixer_sat #(
    .OUT_SHIFT (OUT_SHIFT)
  ) u_sat (
    .acc     (r_acc),
    .y8      (w_y8),
    .clipped (w_clipped)
  );

`ifdef BAND_MIXER_CLIPCNT_EN
  always_ff @(posedge clock) begin
    if (!reset)
      clip_count <= '0;
    else if (w_done && w_clipped && (clip_count != 16'hFFFF))
      clip_count <= clip_count + 16'd1;
  end
`else
  logic w_unused_clipped;
  assign w_unused_clipped = w_clipped;
`endif

endmodule
`default_nettype wire

// File: tb/tb_band_mixer.sv
`default_nettype none
// ============================================================================
// Module   : tb_band_mixer
// Purpose  : Randomised self-checking bench for band_mixer against a plain
//            arithmetic mixing model (clip count checked with BAND_MIXER_CLIPCNT_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_band_mixer;

  logic        clock;
  logic        reset;
  logic        ready;
  logic [17:0] band_in [5];
  logic [3:0]  gain_in [5];
  logic [7:0]  y;
  logic        y_valid;
  logic        busy;
`ifdef BAND_MIXER_CLIPCNT_EN
  logic [15:0] clip_count;
`endif

  logic [17:0] set_band [5];
  logic [3:0]  set_gain [5];
  logic [7:0]  y_model;
  int          clip_model;
  int          n_checks;
  int          n_fails;

  band_mixer u_dut (
    .clock   (clock),
    .reset   (reset),
    .ready   (ready),
    .band0   (band_in[0]),
    .band1   (band_in[1]),
    .band2   (band_in[2]),
    .band3   (band_in[3]),
    .band4   (band_in[4]),
    .gain0   (gain_in[0]),
    .gain1   (gain_in[1]),
    .gain2   (gain_in[2]),
    .gain3   (gain_in[3]),
    .gain4   (gain_in[4]),
    .y       (y),
    .y_valid (y_valid),
    .busy    (busy)
`ifdef BAND_MIXER_CLIPCNT_EN
    ,
    .clip_count (clip_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Expected sample: exact sum, floor shift by 10, clamp to signed 8 bits.
  function automatic int model_y(output bit clip);
    longint sum;
    sum = 0;
    for (int i = 0; i < 5; i++)
      sum += longint'($signed(set_band[i])) * longint'(set_gain[i]);
    sum  = sum >>> 10;
    clip = 1'b0;
    if (sum > 127) begin
      sum  = 127;
      clip = 1'b1;
    end else if (sum < -128) begin
      sum  = -128;
      clip = 1'b1;
    end
    return int'(sum);
  endfunction

  task automatic drive_inputs(input bit rnd);
    for (int i = 0; i < 5; i++) begin
      band_in[i] = rnd ? 18'($urandom) : set_band[i];
      gain_in[i] = rnd ? 4'($urandom)  : set_gain[i];
    end
  endtask

  task automatic set_all(input logic [17:0] b, input logic [3:0] g);
    for (int i = 0; i < 5; i++) begin
      set_band[i] = b;
      set_gain[i] = g;
    end
  endtask

  // One transaction: ready at edge E0, optional second ready at E0+abort_at,
  // optional reset asserted at edge E0+rst_at. k counts edges after E0.
  task automatic run_txn(input bit scramble, input int abort_at, input int rst_at);
    int         base;
    int         ey;
    bit         eclip;
    logic [7:0] prev_y;
    logic [7:0] ey8;
    bit         in_rst;
    base   = (abort_at > 0) ? abort_at : 0;
    ey     = model_y(eclip);
    ey8    = 8'(ey);
    prev_y = y_model;
    ready  = 1'b1;
    drive_inputs(scramble);
    tick();
    ready  = 1'b0;
    for (int k = 0; k <= base + 71; k++) begin
      in_rst = (rst_at > 0) && (k >= rst_at);
      if (in_rst) begin
        check("rst_y", 32'(y), 32'h0);
        check("rst_valid", 32'(y_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
      end else begin
        check("valid", 32'(y_valid), 32'(k == base + 69));
        check("busy", 32'(busy), 32'(k <= base + 68));
        check("y", 32'(y), 32'((k >= base + 69) ? ey8 : prev_y));
      end
      ready = (abort_at > 0) && (k + 1 == abort_at);
      reset = !((rst_at > 0) && (k + 1 == rst_at));
      if (k + 1 == base + 63) drive_inputs(1'b0);
      else                    drive_inputs(scramble);
      tick();
    end
    reset = 1'b1;
    if (rst_at > 0) begin
      y_model    = 8'h00;
      clip_model = 0;
    end else begin
      y_model = ey8;
      if (eclip && clip_model < 65535) clip_model++;
    end
`ifdef BAND_MIXER_CLIPCNT_EN
    check("clip_count", 32'(clip_count), 32'(clip_model));
`endif
  endtask

  initial begin
    n_checks   = 0;
    n_fails    = 0;
    clip_model = 0;
    y_model    = 8'h00;
    reset      = 1'b0;
    ready      = 1'b0;
    set_all(18'd0, 4'd0);
    drive_inputs(1'b0);

    // Reset held while ready pulses: nothing may start.
    for (int i = 0; i < 3; i++) begin
      ready = 1'b1;
      tick();
      check("reset_y", 32'(y), 32'h0);
      check("reset_valid", 32'(y_valid), 32'h0);
      check("reset_busy", 32'(busy), 32'h0);
    end
    ready = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 80; i++) begin
      tick();
      check("post_reset_valid", 32'(y_valid), 32'h0);
      check("post_reset_busy", 32'(busy), 32'h0);
    end
`ifdef BAND_MIXER_CLIPCNT_EN
    check("reset_clip", 32'(clip_count), 32'h0);
`endif

    set_all(18'd1024, 4'd1);
    run_txn(1'b0, 0, 0);

    set_all(18'd0, 4'd0);
    set_band[0] = 18'h1FFFF; set_gain[0] = 4'd15;
    run_txn(1'b0, 0, 0);
    set_band[0] = 18'h20000;
    run_txn(1'b0, 0, 0);

    set_all(18'd0, 4'd0);
    set_band[0] = 18'h3FFFF; set_gain[0] = 4'd1;
    run_txn(1'b0, 0, 0);
    set_all(18'd0, 4'd0);
    set_band[2] = 18'd2047; set_gain[2] = 4'd1;
    run_txn(1'b0, 0, 0);

    set_all(18'd3000, 4'd7);
    run_txn(1'b0, 30, 0);

    set_band[0] = 18'd5000;  set_gain[0] = 4'd3;
    set_band[1] = 18'h3F000; set_gain[1] = 4'd2;
    set_band[3] = 18'd777;   set_gain[3] = 4'd9;
    run_txn(1'b1, 0, 0);
    run_txn(1'b1, 0, 66);

    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < 5; i++) begin
        case ($urandom_range(0, 3))
          0:       set_band[i] = 18'h1FFFF;
          1:       set_band[i] = 18'h20000;
          default: set_band[i] = 18'($urandom);
        endcase
        set_gain[i] = 4'($urandom_range(0, 15));
      end
      run_txn(1'b1, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 69)) : 0, 0);
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        drive_inputs(1'b1);
        tick();
        check("idle_valid", 32'(y_valid), 32'h0);
        check("idle_y", 32'(y), 32'(y_model));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
